button_conditioner: RTL and testbench

- Upstream front end for the note-editor control FSM.
- Takes the five raw, bouncy, asynchronous push-button inputs and synchronises each one to clk.
- Debounces each button independently and emits a clean level plus a single-cycle press pulse per button.
- The FSM consumes btn_pulse directly, so one physical press produces exactly one pitch step or state change.

---
 rtl/btn_pkg.sv | 31 +++
 rtl/btn_debounce_channel.sv | 159 +++++++++++++++
 rtl/button_conditioner.sv | 39 +++
 tb/tb_button_conditioner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: channel state encoding,
// 100 MHz timing defaults and the board's button index assignments.
package btn_pkg;

    // Bit 1 of the encoding is the debounced level, so both "held" states share it.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEF_NUM_BTN         = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms at 100 MHz
    localparam int DEF_CNT_W           = 20;
    localparam int DEF_REPEAT_DELAY    = 50000000;  // 500 ms before the first repeat
    localparam int DEF_REPEAT_PERIOD   = 10000000;  // 100 ms between repeats

    localparam int BTN_CENTER = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 2;
    localparam int BTN_PLAY   = 4;

    // Width needed to hold the larger of the two repeat terminal counts.
    function automatic int rep_width(input int delay, input int period);
        int top_val;
        top_val = (delay > period) ? delay : period;
        return (top_val < 2) ? 1 : $clog2(top_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop synchroniser, 4-state debounce FSM with a shared counter,
// registered press pulse. Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
import btn_pkg::*;

module btn_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    output btn_state_e state,
    output logic       pulse
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce_channel: DEBOUNCE_CYCLES must be at least 2");
    end
    if ((DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("btn_debounce_channel: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce_channel: repeat timing must be at least 1 cycle");
    end

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_fire;
    logic             pulse_d, pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // The count is the number of consecutive samples seen at the new level; any
    // opposite sample drops back to the settled state, so no saturation is needed.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        press_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_PRESSED;
                    cnt_d      = '0;
                    press_fire = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int               REP_W     = rep_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;
    logic             rep_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end

    // Counts only while settled in PRESSED with the button still down; a bounce
    // into RELEASE_WAIT freezes it and only a full release clears it.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (state_q == ST_IDLE) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (state_q == ST_PRESSED && s) begin
            if (rep_cnt_q == (rep_armed_q ? REP_NEXT : REP_FIRST)) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_ONE;
            end
        end
    end

    assign pulse_d = press_fire | rep_fire;
`else
    assign pulse_d = press_fire;
`endif

    assign state = state_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Front end for the note-editor FSM: NUM_BTN independent synchronise/debounce
// channels. Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses.
import btn_pkg::*;

module button_conditioner #(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    btn_state_e chan_state [NUM_BTN];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (btn_raw[i]),
            .state   (chan_state[i]),
            .pulse   (btn_pulse[i])
        );

        // Level is the state register's top bit: high in PRESSED and RELEASE_WAIT.
        assign btn_level[i] = chan_state[i][1];
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int CW = 3;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [2*NB-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a level flips once the last DB synchronised samples all
    // disagree with it; samples lag the pad by two edges.
    logic [NB-1:0] m_raw_d1, m_raw_d2, m_lvl;
    logic [DB-1:0] m_win [NB];
    int            m_hold [NB];

    task automatic model_edge();
        logic [NB-1:0] pul;
        logic          s, prev;
        pul = '0;
        if (!rst_n) begin
            m_raw_d1 = '0;
            m_raw_d2 = '0;
            m_lvl    = '0;
            for (int i = 0; i < NB; i++) begin
                m_win[i]  = '0;
                m_hold[i] = 0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                s        = m_raw_d2[i];
                prev     = m_win[i][0];
                m_win[i] = {m_win[i][DB-2:0], s};
                if (!m_lvl[i] && m_win[i] == '1) begin
                    m_lvl[i]  = 1'b1;
                    pul[i]    = 1'b1;
                    m_hold[i] = 0;
                end else if (m_lvl[i] && m_win[i] == '0) begin
                    m_lvl[i]  = 1'b0;
                    m_hold[i] = 0;
                end else if (m_lvl[i] && s && prev) begin
`ifdef BTN_AUTOREPEAT_EN
                    m_hold[i]++;
                    if (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RP == 0))
                        pul[i] = 1'b1;
`endif
                end
            end
            m_raw_d2 = m_raw_d1;
            m_raw_d1 = btn_raw;
        end
        exp_q.push_back({m_lvl, pul});
    endtask

    // ---------------- driver ----------------
    // One clock: the model consumes the inputs at the edge, DUT is compared at the next negedge.
    task automatic tick();
        logic [2*NB-1:0] e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got no expected entry for cycle at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("sb_level", 32'(btn_level), 32'(e[2*NB-1:NB]));
            check("sb_pulse", 32'(btn_pulse), 32'(e[NB-1:0]));
        end
    endtask

    typedef struct {
        logic [NB-1:0] raw;
        int            cycles;
        logic [NB-1:0] exp_level;
        int            exp_pulses;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int n;
        int pc;

        vecs[0]  = '{5'b00000, 8,  5'b00000, 0};
        vecs[1]  = '{5'b00001, 12, 5'b00001, 1};  // clean press
        vecs[2]  = '{5'b00000, 8,  5'b00000, 0};  // release, no pulse
        vecs[3]  = '{5'b00010, 3,  5'b00000, 0};  // glitch shorter than debounce
        vecs[4]  = '{5'b00000, 8,  5'b00000, 0};
        vecs[5]  = '{5'b10001, 10, 5'b10001, 2};  // simultaneous press
        vecs[6]  = '{5'b00000, 8,  5'b00000, 0};
        vecs[7]  = '{5'b00100, 1,  5'b00000, 0};  // bounce 1,0,1,0
        vecs[8]  = '{5'b00000, 1,  5'b00000, 0};
        vecs[9]  = '{5'b00100, 1,  5'b00000, 0};
        vecs[10] = '{5'b00000, 1,  5'b00000, 0};
        vecs[11] = '{5'b00100, 12, 5'b00100, 1};  // stable after bounce
        vecs[12] = '{5'b00000, 8,  5'b00000, 0};
        vecs[13] = '{5'b11111, 10, 5'b11111, 5};  // every channel together
        vecs[14] = '{5'b00000, 8,  5'b00000, 0};

        // ---------------- reset ----------------
        rst_n   = 1'b0;
        btn_raw = '0;
        repeat (3) tick();
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_pulse", 32'(btn_pulse), 32'd0);
        rst_n = 1'b1;

        // ---------------- table-driven segments ----------------
        for (int v = 0; v < 15; v++) begin
            btn_raw = vecs[v].raw;
            pc = 0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                tick();
                pc += $countones(btn_pulse);
            end
            check($sformatf("seg%0d_level", v), 32'(btn_level), 32'(vecs[v].exp_level));
            check($sformatf("seg%0d_pulses", v), 32'(pc), 32'(vecs[v].exp_pulses));
        end

        // ---------------- press / release latency ----------------
        btn_raw = 5'b00001;
        n = 0;
        do begin tick(); n++; end while (!btn_pulse[0] && n < 20);
        check("press_latency", 32'(n), 32'd6);
        check("press_level", 32'(btn_level[0]), 32'd1);
        tick();
        check("pulse_one_cycle", 32'(btn_pulse[0]), 32'd0);
        repeat (5) tick();
        btn_raw = '0;
        n = 0;
        pc = 0;
        do begin tick(); n++; pc += int'(btn_pulse[0]); end while (btn_level[0] && n < 20);
        check("release_latency", 32'(n), 32'd6);
        check("no_release_pulse", 32'(pc), 32'd0);
        repeat (4) tick();

        // ---------------- simultaneous rise ----------------
        btn_raw = 5'b10001;
        n = 0;
        do begin tick(); n++; end while (btn_pulse == '0 && n < 20);
        check("simul_latency", 32'(n), 32'd6);
        check("simul_pulse", 32'(btn_pulse), 32'b10001);
        btn_raw = '0;
        repeat (8) tick();

        // ---------------- reset mid-debounce ----------------
        btn_raw = 5'b00010;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_level", 32'(btn_level), 32'd0);
        check("rst_mid_pulse", 32'(btn_pulse), 32'd0);
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!btn_pulse[1] && n < 20);
        check("rst_latency", 32'(n), 32'd6);
        btn_raw = '0;
        repeat (8) tick();

        // ---------------- long hold on btn[2] ----------------
        btn_raw = 5'b00100;
        pc = 0;
        repeat (30) begin tick(); pc += int'(btn_pulse[2]); end
        btn_raw = '0;
        repeat (10) begin tick(); pc += int'(btn_pulse[2]); end
`ifdef BTN_AUTOREPEAT_EN
        check("hold_pulses", 32'(pc), 32'd7);
`else
        check("hold_pulses", 32'(pc), 32'd1);
`endif
        check("hold_released", 32'(btn_level), 32'd0);

        // ---------------- random bursts ----------------
        repeat (30) begin
            btn_raw = 5'($urandom_range(0, 31));
            repeat ($urandom_range(1, 8)) tick();
        end
        btn_raw = '0;
        repeat (10) tick();
        check("final_idle", 32'(btn_level), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
